fu_operand_collect: RTL and testbench
=====================================

Name: fu_operand_collect

Overview:
- Operand-collection stage directly upstream of the functional-unit compute logic.
- Accepts left and right operands from the switch fabric over two independent valid/credit channels.
- Buffers each channel in a small FIFO.
- When both operands are present and the downstream output stage has a credit, presents the operand pair to the compute logic with a one-cycle `ready_in` fire pulse, and returns one credit to each producing switch.

Parameters:
- DEPTH, 2, entries per operand FIFO; also the number of credits the upstream switch is initialised with. Legal values: 2 to 8.
- OUT_CREDITS, 2, initial credit count toward the downstream output stage. Legal values: 1 to 15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- l_valid  in  1  left operand valid from switch.
- l_data  in  `DATA_WIDTH+1  left operand.
- l_credit  out  1  one-cycle pulse: one left FIFO entry freed.
- r_valid  in  1  right operand valid from switch.
- r_data  in  `DATA_WIDTH+1  right operand.
- r_credit  out  1  one-cycle pulse: one right FIFO entry freed.
- cfg_imm_en  in  1  static: right operand taken from cfg_imm; the right channel is ignored.
- cfg_imm  in  `DATA_WIDTH+1  static immediate right operand.
- out_credit  in  1  one-cycle pulse from the downstream output stage returning one credit.
- fire  out  1  registered operand-pair valid; drives the compute logic's `ready_in`.
- d_in_L  out  `DATA_WIDTH+1  registered left operand to the compute logic.
- d_in_R  out  `DATA_WIDTH+1  registered right operand to the compute logic.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Both FIFOs empty; credit counter = OUT_CREDITS.
  - fire, l_credit, r_credit, err = 0; d_in_L, d_in_R = 0.
  - Reset asserted mid-operation flushes all buffered operands. The upstream switch re-initialises its own credits on the same reset.
- Enqueue: on a clock edge with l_valid=1, l_data is written to the left FIFO. The right FIFO is handled identically.
  - When cfg_imm_en=1, r_valid is ignored and no write occurs.
- Fire condition, evaluated combinationally each cycle:
  - can_fire = left FIFO non-empty AND (cfg_imm_en OR right FIFO non-empty) AND credit counter > 0.
- On the edge where can_fire=1:
  - Pop the left head, and pop the right head unless cfg_imm_en.
  - Register d_in_L = left head; d_in_R = right head, or cfg_imm when cfg_imm_en.
  - Register fire=1 for exactly one cycle.
  - Decrement the credit counter.
- d_in_L/d_in_R hold their last values when fire=0.
- Latency: data written at edge t is visible as non-empty in cycle t+1. If the fire condition is met in cycle t+1, fire is high in cycle t+2. Minimum pass-through latency is 2 cycles.
- Throughput: one fire per cycle while both FIFOs are non-empty and credits remain.
- Credits: l_credit is registered and high in the cycle after each left pop. r_credit is the same for right pops and is never asserted while cfg_imm_en=1.
- Simultaneous events:
  - Enqueue and pop on the same FIFO in the same cycle is legal at any occupancy except: enqueue when full with no pop.
  - A FIFO that is full and popping accepts the new write in the same edge.
  - An empty FIFO never bypasses; written data fires no earlier than the next cycle.
  - out_credit and fire on the same edge leave the counter unchanged.
- Error and boundary rules:
  - Enqueue into a full FIFO with no simultaneous pop: the data is dropped and err is set. This is an upstream credit violation.
  - out_credit while the counter equals OUT_CREDITS: the counter saturates and err is set.
  - err clears only on reset.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy is tracked with a separate count of width log2(DEPTH)+1, so full and empty are unambiguous.
- cfg_imm_en and cfg_imm are static while operands are in flight. Changing them mid-stream is undefined.

Decomposition:
- Add the following shared constants to dyser_config.v, so the compute logic and switch stages agree:
  - Default operand FIFO depth.
  - Default output credit count.
  - Credit counter width.
- One sub-module, fu_op_fifo: a parameterised DEPTH x (`DATA_WIDTH+1) synchronous FIFO.
  - Ports: push, pop, data in, head out, empty, full, overflow pulse.
  - Instantiated twice: left and right.
- Top-level logic is the fire/credit control and output registers.

Test Plan:
- Basic pair: after reset, l_data=0x0000_0005 and r_data=0x0000_0003 written the same cycle t → fire=1 in cycle t+2 with d_in_L=5, d_in_R=3; l_credit and r_credit each pulse once, in cycle t+2.
- Skewed arrival: left written at t, right at t+3 → fire stays 0 until cycle t+5; left data is preserved in the FIFO with no loss.
- Credit stall: OUT_CREDITS=2, four pairs enqueued back-to-back with no out_credit → exactly 2 fires. One out_credit pulse → exactly 1 more fire. Remaining pairs keep FIFOs full and no credits return upstream.
- Immediate mode: cfg_imm_en=1, cfg_imm=0xFFFF_FFF0, three left writes with r_valid toggling → 3 fires with d_in_R=0xFFFF_FFF0 each; r_credit never pulses.
- Overflow/err: DEPTH=2, three left writes with no right data → third write dropped and err=1. Subsequent right writes fire the first two left values only, in order.
- Async reset mid-stream: rst_n low between clock edges with one entry in each FIFO and fire high → fire, err and credit pulses drop to 0 immediately. After release, no fire occurs until new operands arrive.

Source files
------------

// File: rtl/fu_operand_collect_pkg.sv
// Shared constants and types for the functional-unit operand-collection stage,
// so the compute logic and switch stages agree on widths and credit defaults.
package fu_operand_collect_pkg;

    localparam int DATA_WIDTH      = 32;
    localparam int OP_W            = DATA_WIDTH + 1;
    localparam int DEF_FIFO_DEPTH  = 2;
    localparam int DEF_OUT_CREDITS = 2;
    localparam int CREDIT_W        = 4;

    typedef logic [OP_W-1:0] operand_t;

endpackage

// File: rtl/fu_op_fifo.sv
// DEPTH-entry synchronous operand FIFO with wrap-around pointers, an explicit
// occupancy count and an overflow pulse for a push into a full, non-popping FIFO.
module fu_op_fifo
    import fu_operand_collect_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [OP_W-1:0] din,
    output logic [OP_W-1:0] head,
    output logic            empty,
    output logic            full,
    output logic            overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    operand_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;
    assign head     = mem[rd_ptr];

    // NOTE: storage is deliberately left out of reset; count alone decides
    // validity, so flushing the pointers is enough and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fu_operand_collect.sv
// Operand-collection stage: buffers left/right operands, fires a registered
// pair to the compute logic when both are present and a downstream credit exists.
module fu_operand_collect
    import fu_operand_collect_pkg::*;
#(
    parameter int DEPTH       = DEF_FIFO_DEPTH,
    parameter int OUT_CREDITS = DEF_OUT_CREDITS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            l_valid,
    input  logic [OP_W-1:0] l_data,
    output logic            l_credit,
    input  logic            r_valid,
    input  logic [OP_W-1:0] r_data,
    output logic            r_credit,
    input  logic            cfg_imm_en,
    input  logic [OP_W-1:0] cfg_imm,
    input  logic            out_credit,
    output logic            fire,
    output logic [OP_W-1:0] d_in_L,
    output logic [OP_W-1:0] d_in_R,
    output logic            err
);

    localparam logic [CREDIT_W-1:0] CRED_MAX = CREDIT_W'(OUT_CREDITS);

    logic [OP_W-1:0]     l_head;
    logic [OP_W-1:0]     r_head;
    logic                l_empty, l_full, l_ovf;
    logic                r_empty, r_full, r_ovf;
    logic [CREDIT_W-1:0] credits;
    logic                can_fire;
    logic                credit_ovf;

    assign can_fire   = !l_empty && (cfg_imm_en || !r_empty) && (credits != '0);
    assign credit_ovf = out_credit && (credits == CRED_MAX);

    fu_op_fifo #(.DEPTH(DEPTH)) u_left_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (l_valid),
        .pop      (can_fire),
        .din      (l_data),
        .head     (l_head),
        .empty    (l_empty),
        .full     (l_full),
        .overflow (l_ovf)
    );

    // In immediate mode the right channel is inert: no writes, no pops.
    fu_op_fifo #(.DEPTH(DEPTH)) u_right_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (r_valid && !cfg_imm_en),
        .pop      (can_fire && !cfg_imm_en),
        .din      (r_data),
        .head     (r_head),
        .empty    (r_empty),
        .full     (r_full),
        .overflow (r_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits  <= CRED_MAX;
            fire     <= 1'b0;
            l_credit <= 1'b0;
            r_credit <= 1'b0;
            err      <= 1'b0;
            d_in_L   <= '0;
            d_in_R   <= '0;
        end else begin
            fire     <= can_fire;
            l_credit <= can_fire;
            r_credit <= can_fire && !cfg_imm_en;
            if (can_fire) begin
                d_in_L <= l_head;
                d_in_R <= cfg_imm_en ? cfg_imm : r_head;
            end
            // A returned credit and a fire on the same edge cancel out.
            if (can_fire && !out_credit)
                credits <= credits - 1'b1;
            else if (out_credit && !can_fire && !credit_ovf)
                credits <= credits + 1'b1;
            if (l_ovf || r_ovf || credit_ovf)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fu_operand_collect.sv
// Randomised and directed bench for fu_operand_collect against a queue-based
// reference model of the operand-pairing and credit rules.
module tb_fu_operand_collect;
    import fu_operand_collect_pkg::*;

    localparam int DEPTH       = 2;
    localparam int OUT_CREDITS = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            l_valid, r_valid, cfg_imm_en, out_credit;
    logic [OP_W-1:0] l_data, r_data, cfg_imm;
    logic            l_credit, r_credit, fire, err;
    logic [OP_W-1:0] d_in_L, d_in_R;

    fu_operand_collect #(.DEPTH(DEPTH), .OUT_CREDITS(OUT_CREDITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .l_valid    (l_valid),
        .l_data     (l_data),
        .l_credit   (l_credit),
        .r_valid    (r_valid),
        .r_data     (r_data),
        .r_credit   (r_credit),
        .cfg_imm_en (cfg_imm_en),
        .cfg_imm    (cfg_imm),
        .out_credit (out_credit),
        .fire       (fire),
        .d_in_L     (d_in_L),
        .d_in_R     (d_in_R),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int fire_cnt, rc_cnt;

    // Reference model state
    operand_t lq[$];
    operand_t rq[$];
    int       m_credits;
    bit       m_err, m_fire, m_lc, m_rc;
    operand_t m_L, m_R;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("fire", 64'(fire), 64'(m_fire));
        check("l_credit", 64'(l_credit), 64'(m_lc));
        check("r_credit", 64'(r_credit), 64'(m_rc));
        check("err", 64'(err), 64'(m_err));
        check("d_in_L", 64'(d_in_L), 64'(m_L));
        check("d_in_R", 64'(d_in_R), 64'(m_R));
    endtask

    task automatic model_reset();
        lq.delete();
        rq.delete();
        m_credits = OUT_CREDITS;
        m_err = 0; m_fire = 0; m_lc = 0; m_rc = 0;
        m_L = '0; m_R = '0;
    endtask

    // Advance one clock: update the model from current inputs, then compare.
    task automatic step();
        int lsz = lq.size();
        int rsz = rq.size();
        bit can = (lsz > 0) && (cfg_imm_en || rsz > 0) && (m_credits > 0);
        m_fire = can;
        m_lc   = can;
        m_rc   = can && !cfg_imm_en;
        if (can) begin
            m_L = lq.pop_front();
            if (cfg_imm_en) m_R = cfg_imm;
            else            m_R = rq.pop_front();
        end
        if (l_valid) begin
            if (lsz == DEPTH && !can) m_err = 1;
            else                      lq.push_back(l_data);
        end
        if (r_valid && !cfg_imm_en) begin
            if (rsz == DEPTH && !can) m_err = 1;
            else                      rq.push_back(r_data);
        end
        if (out_credit && m_credits == OUT_CREDITS) m_err = 1;
        if (out_credit && !can && m_credits < OUT_CREDITS) m_credits++;
        else if (can && !out_credit)                       m_credits--;
        @(posedge clk);
        #1;
        check_outputs();
        if (fire)     fire_cnt++;
        if (r_credit) rc_cnt++;
    endtask

    task automatic clear_inputs();
        l_valid = 0; r_valid = 0; out_credit = 0;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        repeat (n) step();
    endtask

    task automatic push_pair(input operand_t l, input operand_t r);
        l_valid = 1; l_data = l;
        r_valid = 1; r_data = r;
        step();
        clear_inputs();
    endtask

    // Return credits as the downstream stage would, until everything drains.
    task automatic drain();
        clear_inputs();
        repeat (16) begin
            out_credit = (m_credits < OUT_CREDITS);
            step();
        end
        out_credit = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1;
    endtask

    function automatic operand_t rand_op();
        return {1'($urandom_range(0, 1)), $urandom()};
    endfunction

    initial begin
        rst_n = 1; cfg_imm_en = 0; cfg_imm = '0;
        l_data = '0; r_data = '0;
        clear_inputs();
        #2;
        do_reset();

        // Basic pair
        push_pair(33'h5, 33'h3);
        idle(3);

        // Skewed arrival: left at t, right at t+3
        l_valid = 1; l_data = 33'h1_2345_6789;
        step();
        idle(2);
        r_valid = 1; r_data = 33'h0_0BAD_F00D;
        step();
        idle(3);
        drain();

        // Credit stall
        fire_cnt = 0;
        for (int i = 0; i < 4; i++) push_pair(rand_op(), rand_op());
        idle(4);
        check("stall_fires", 64'(fire_cnt), 64'd2);
        fire_cnt = 0;
        out_credit = 1;
        step();
        idle(3);
        check("stall_one_more", 64'(fire_cnt), 64'd1);
        drain();

        // Immediate mode
        cfg_imm_en = 1; cfg_imm = 33'h0_FFFF_FFF0;
        fire_cnt = 0; rc_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            l_valid = 1; l_data = rand_op();
            r_valid = (i % 2 == 0); r_data = rand_op();
            out_credit = (m_credits < OUT_CREDITS);
            step();
        end
        drain();
        check("imm_fires", 64'(fire_cnt), 64'd3);
        check("imm_r_credit", 64'(rc_cnt), 64'd0);
        cfg_imm_en = 0;

        // Overflow: third left write dropped
        fire_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            l_valid = 1; l_data = 33'(100 + i);
            step();
        end
        clear_inputs();
        check("ovf_err", 64'(err), 64'd1);
        r_valid = 1; r_data = 33'h11; step();
        r_valid = 1; r_data = 33'h22; step();
        drain();
        check("ovf_fires", 64'(fire_cnt), 64'd2);

        // Credit over-return sets err, then async reset mid-stream
        do_reset();
        out_credit = 1;
        step();
        clear_inputs();
        push_pair(rand_op(), rand_op());
        push_pair(rand_op(), rand_op());
        check("pre_rst_fire", 64'(fire), 64'd1);
        do_reset();
        idle(4);

        // Randomised traffic obeying upstream and downstream credit rules
        for (int i = 0; i < 400; i++) begin
            l_valid    = ($urandom_range(0, 3) != 0) && (lq.size() < DEPTH);
            r_valid    = ($urandom_range(0, 3) != 0) && (rq.size() < DEPTH);
            l_data     = rand_op();
            r_data     = rand_op();
            out_credit = ($urandom_range(0, 2) != 0) && (m_credits < OUT_CREDITS);
            step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
